// File: rtl/rtc_pps_capture.sv
// rtc_pps_capture: PPS synchronizer, period measurement, lock tracking and RTC timestamp stream.
// Optional glitch filter on the synchronized level when RTC_PPS_CAPTURE_GLITCH_FILTER_EN is defined.
module rtc_pps_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 28,
    parameter int PERIOD_MIN  = 99_990_000,
    parameter int PERIOD_MAX  = 100_010_000,
    parameter int FILTER_LEN  = 4
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 pps_in,
    input  logic [31:0]          rtc_sec,
    input  logic [31:0]          rtc_nsec,
    output logic [31:0]          m_ts_sec,
    output logic [31:0]          m_ts_nsec,
    output logic [CNT_WIDTH-1:0] m_ts_period,
    output logic                 m_ts_good,
    output logic                 m_ts_valid,
    input  logic                 m_ts_ready,
    output logic                 pps_locked,
    output logic                 pps_missing,
    output logic [7:0]           drop_cnt
);
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_bad_cfg
        $error("rtc_pps_capture: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d, level, edge_det, in_win, timeout, load;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, per_q, per_d;
    logic [1:0]             state_q, state_d;
    logic [31:0]            sec_q, sec_d, nsec_q, nsec_d;
    logic                   good_q, good_d, valid_q, valid_d, miss_q, miss_d;
    logic [7:0]             drop_q, drop_d;

`ifdef RTC_PPS_CAPTURE_GLITCH_FILTER_EN
    localparam int FW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
    logic [FW-1:0] fcnt_q, fcnt_d;

    // The filtered level is prev_q; it follows the sync output only after FILTER_LEN stable cycles.
    always_comb begin
        level  = (sync_q[SYNC_STAGES-1] != prev_q && fcnt_q == FW'(FILTER_LEN - 1)) ? sync_q[SYNC_STAGES-1] : prev_q;
        fcnt_d = (level == sync_q[SYNC_STAGES-1]) ? '0 : fcnt_q + 1'b1;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) fcnt_q <= '0;
        else        fcnt_q <= fcnt_d;
    end
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    // Counter holds cycles elapsed since the last edge cycle, so the edge cycle itself counts as 0.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pps_in};
        prev_d   = level;
        edge_det = level & ~prev_q;
        in_win   = cnt_q >= CNT_WIDTH'(PERIOD_MIN) && cnt_q <= CNT_WIDTH'(PERIOD_MAX);
        timeout  = !edge_det && state_q != SEARCH && cnt_q == CNT_WIDTH'(PERIOD_MAX + 1);
        cnt_d    = edge_det ? CNT_WIDTH'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
        state_d  = edge_det ? ((state_q != SEARCH && in_win) ? LOCKED : CHECK) : (timeout ? SEARCH : state_q);
        load     = edge_det & (~valid_q | m_ts_ready);
        sec_d    = load ? rtc_sec : sec_q;
        nsec_d   = load ? rtc_nsec : nsec_q;
        per_d    = load ? cnt_q : per_q;
        good_d   = load ? (in_win && state_q != SEARCH) : good_q;
        valid_d  = load | (valid_q & ~m_ts_ready);
        miss_d   = timeout;
        drop_d   = (edge_det && !load && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= SEARCH;
            sec_q   <= '0;
            nsec_q  <= '0;
            per_q   <= '0;
            good_q  <= 1'b0;
            valid_q <= 1'b0;
            miss_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            sec_q   <= sec_d;
            nsec_q  <= nsec_d;
            per_q   <= per_d;
            good_q  <= good_d;
            valid_q <= valid_d;
            miss_q  <= miss_d;
            drop_q  <= drop_d;
        end
    end

    assign m_ts_sec    = sec_q;
    assign m_ts_nsec   = nsec_q;
    assign m_ts_period = per_q;
    assign m_ts_good   = good_q;
    assign m_ts_valid  = valid_q;
    assign pps_locked  = state_q == LOCKED;
    assign pps_missing = miss_q;
    assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_rtc_pps_capture.sv
// tb_rtc_pps_capture: randomized PPS pulse trains checked every cycle against a record-level reference model.
// Also exercises the glitch filter when RTC_PPS_CAPTURE_GLITCH_FILTER_EN is defined.
module tb_rtc_pps_capture;
    localparam int CW   = 8;
    localparam int PMIN = 90;
    localparam int PMAX = 110;
    localparam int SMAX = 255;
`ifdef RTC_PPS_CAPTURE_GLITCH_FILTER_EN
    localparam int FLEN = 4;
`else
    localparam int FLEN = 1;
`endif

    logic          aclk = 1'b0, areset = 1'b1, pps_in = 1'b0, m_ts_ready = 1'b1;
    logic [31:0]   rtc_sec = '0, rtc_nsec = '0;
    logic [31:0]   m_ts_sec, m_ts_nsec;
    logic [CW-1:0] m_ts_period;
    logic          m_ts_good, m_ts_valid, pps_locked, pps_missing;
    logic [7:0]    drop_cnt;

    rtc_pps_capture #(
        .SYNC_STAGES(2), .CNT_WIDTH(CW), .PERIOD_MIN(PMIN), .PERIOD_MAX(PMAX), .FILTER_LEN(4)
    ) dut (
        .aclk(aclk), .areset(areset), .pps_in(pps_in), .rtc_sec(rtc_sec), .rtc_nsec(rtc_nsec),
        .m_ts_sec(m_ts_sec), .m_ts_nsec(m_ts_nsec), .m_ts_period(m_ts_period), .m_ts_good(m_ts_good),
        .m_ts_valid(m_ts_valid), .m_ts_ready(m_ts_ready), .pps_locked(pps_locked),
        .pps_missing(pps_missing), .drop_cnt(drop_cnt)
    );

    always #5 aclk = ~aclk;

    // Model: 0 = SEARCH, 1 = CHECK, 2 = LOCKED; edges are scheduled by absolute cycle number.
    int          checks = 0, errors = 0, cyc = 0, last_e = 1, drop = 0, mstate = 0, hper = 0;
    int          edge_q[$];
    logic [31:0] key, hsec, hnsec;
    logic        hv = 1'b0, hgood = 1'b0, miss_e = 1'b0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int per;
        bit inw;
        @(posedge aclk);
        #1;
        cyc++;
        miss_e = 1'b0;
        if (areset) begin
            mstate = 0; hv = 1'b0; drop = 0; last_e = cyc + 1;
            edge_q.delete();
        end else if (edge_q.size() > 0 && edge_q[0] == cyc) begin
            void'(edge_q.pop_front());
            per = (cyc - last_e > SMAX) ? SMAX : cyc - last_e;
            inw = per >= PMIN && per <= PMAX;
            if (!hv || m_ts_ready) begin
                hv = 1'b1; hsec = 32'(cyc - 1) ^ key; hnsec = 32'(cyc - 1); hper = per;
                hgood = inw && mstate != 0;
            end else if (drop < 255) drop++;
            mstate = (mstate != 0 && inw) ? 2 : 1;
            last_e = cyc;
        end else begin
            if (hv && m_ts_ready) hv = 1'b0;
            if (mstate != 0 && cyc - last_e == PMAX + 1) begin
                miss_e = 1'b1; mstate = 0;
            end
        end
        chk("valid", 64'(m_ts_valid), 64'(hv));
        if (hv) begin
            chk("sec", 64'(m_ts_sec), 64'(hsec));
            chk("nsec", 64'(m_ts_nsec), 64'(hnsec));
            chk("period", 64'(m_ts_period), 64'(hper));
            chk("good", 64'(m_ts_good), 64'(hgood));
        end
        chk("locked", 64'(pps_locked), 64'(mstate == 2));
        chk("missing", 64'(pps_missing), 64'(miss_e));
        chk("drop_cnt", 64'(drop_cnt), 64'(drop));
        rtc_nsec = 32'(cyc);
        rtc_sec  = 32'(cyc) ^ key;
    endtask

    // Rise now, stay high w cycles, next rise gap cycles after this one.
    task automatic pulse(int gap, int w);
        pps_in = 1'b1;
        if (w >= FLEN) edge_q.push_back(cyc + 3 + FLEN - 1);
        repeat (w) tick();
        pps_in = 1'b0;
        repeat (gap - w) tick();
    endtask

    initial begin
        int p, nmiss;
        int gaps[5] = '{89, 90, 110, 111, 112};
        logic [31:0] held;
        key = $urandom;
        #1;
        chk("reset_valid", 64'(m_ts_valid), 64'd0);
        chk("reset_locked", 64'(pps_locked), 64'd0);
        chk("reset_drop", 64'(drop_cnt), 64'd0);
        repeat (4) tick();
        areset = 1'b0;
        repeat (20) tick();

        pulse(100, 10);
        chk("acq_first_good", 64'(m_ts_good), 64'd0);
        p = cyc;
        pulse(100, 10);
        chk("acq_period", 64'(m_ts_period), 64'd100);
        chk("acq_good", 64'(m_ts_good), 64'd1);
        chk("acq_locked", 64'(pps_locked), 64'd1);
        chk("acq_nsec", 64'(m_ts_nsec), 64'(p + 2 + FLEN - 1));

        pulse(80, 10);
        pulse(100, 10);
        chk("bad_period", 64'(m_ts_period), 64'd80);
        chk("bad_good", 64'(m_ts_good), 64'd0);
        chk("bad_locked", 64'(pps_locked), 64'd0);
        pulse(100, 10);
        chk("relock_good", 64'(m_ts_good), 64'd1);
        chk("relock_locked", 64'(pps_locked), 64'd1);

        for (int i = 0; i < 16; i++) begin
            p = (i % 2 == 0) ? gaps[$urandom_range(0, 4)] : int'($urandom_range(85, 115));
            pulse(p, int'($urandom_range(FLEN, 10)));
        end

        repeat (3) pulse(100, 10);
        chk("loss_pre_locked", 64'(pps_locked), 64'd1);
        nmiss = 0;
        repeat (300) begin
            tick();
            nmiss += int'(pps_missing);
        end
        chk("loss_missing_pulses", 64'(nmiss), 64'd1);
        chk("loss_locked", 64'(pps_locked), 64'd0);
        pulse(100, 10);
        chk("loss_sat_period", 64'(m_ts_period), 64'(SMAX));
        chk("loss_good", 64'(m_ts_good), 64'd0);

        for (int i = 0; i < 300; i++) begin
            m_ts_ready = 1'b0;
            pulse(2 * FLEN + 2, FLEN + 1);
            held = m_ts_nsec;
            pulse(2 * FLEN + 2, FLEN + 1);
            if (i == 0) begin
                chk("bp_drop1", 64'(drop_cnt), 64'd1);
                chk("bp_held", 64'(m_ts_nsec), 64'(held));
                chk("bp_valid_held", 64'(m_ts_valid), 64'd1);
            end
            m_ts_ready = 1'b1;
            tick();
        end
        chk("bp_drop_sat", 64'(drop_cnt), 64'd255);

        m_ts_ready = 1'b0;
        pulse(20, 5);
        chk("rst_pre_valid", 64'(m_ts_valid), 64'd1);
        #3;
        areset = 1'b1;
        #1;
        chk("rst_valid", 64'(m_ts_valid), 64'd0);
        chk("rst_sec", 64'(m_ts_sec), 64'd0);
        chk("rst_nsec", 64'(m_ts_nsec), 64'd0);
        chk("rst_period", 64'(m_ts_period), 64'd0);
        chk("rst_good", 64'(m_ts_good), 64'd0);
        chk("rst_locked", 64'(pps_locked), 64'd0);
        chk("rst_missing", 64'(pps_missing), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        m_ts_ready = 1'b1;
        repeat (3) tick();
        areset = 1'b0;
        repeat (5) tick();
        pulse(100, 10);
        chk("post_rst_good", 64'(m_ts_good), 64'd0);
        chk("post_rst_drop", 64'(drop_cnt), 64'd0);

`ifdef RTC_PPS_CAPTURE_GLITCH_FILTER_EN
        p = cyc;
        pulse(40, 2);
        chk("filt_short_nsec", 64'(m_ts_nsec == 32'(p + 2 + FLEN - 1)), 64'd0);
        p = cyc;
        pulse(40, 4);
        chk("filt_nsec", 64'(m_ts_nsec), 64'(p + 5));
`endif
        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
